// File: rtl/tc3_serial_scheduler.sv
// Bit-serial carry-less multiplier over GF(2)[x]: one shift-and-xor engine is shared
// across the nine 3-way limb products, each accumulated at offset (i+j)*LIMB.
module tc3_serial_scheduler #(
    parameter int N    = 571,
    parameter int LIMB = 191
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] c,
    output logic [1:0]     o_dbg_state
);

    localparam int W3 = 3 * LIMB;
    localparam int PW = 2 * LIMB;
    localparam int AW = 6 * LIMB;
    localparam int BW = $clog2(LIMB);

    // Handshake: a multiply is accepted on a rising edge where start=1 and ready=1;
    // busy=~ready; done pulses for one cycle and c then holds until the next done or rst.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [PW-1:0]    r_p;
    logic [AW-1:0]    r_acc;
    logic [3:0]       r_k;
    logic [BW-1:0]    r_bit;
    logic             r_done;
    logic [2*N-1:0]   r_c;

    logic [W3-1:0]    w_a_ext;
    logic [W3-1:0]    w_b_ext;
    logic [1:0]       w_i;
    logic [1:0]       w_j;
    logic [LIMB-1:0]  w_a_limb;
    logic [LIMB-1:0]  w_b_limb;
    logic [PW-1:0]    w_mul_term;
    logic [2:0]       w_sum;
    logic [AW-1:0]    w_acc_next;
    logic             w_last_bit;
    logic             w_final;
    logic             w_unused_acc;

    assign w_a_ext = W3'(r_a);
    assign w_b_ext = W3'(r_b);

    // Fixed pair order, grouped by output offset i+j.
    always_comb begin
        w_i = 2'd0;
        w_j = 2'd0;
        case (r_k)
            4'd0:    begin w_i = 2'd0; w_j = 2'd0; end
            4'd1:    begin w_i = 2'd0; w_j = 2'd1; end
            4'd2:    begin w_i = 2'd1; w_j = 2'd0; end
            4'd3:    begin w_i = 2'd0; w_j = 2'd2; end
            4'd4:    begin w_i = 2'd1; w_j = 2'd1; end
            4'd5:    begin w_i = 2'd2; w_j = 2'd0; end
            4'd6:    begin w_i = 2'd1; w_j = 2'd2; end
            4'd7:    begin w_i = 2'd2; w_j = 2'd1; end
            default: begin w_i = 2'd2; w_j = 2'd2; end
        endcase
    end

    always_comb begin
        w_a_limb = w_a_ext[0 +: LIMB];
        w_b_limb = w_b_ext[0 +: LIMB];
        case (w_i)
            2'd0:    w_a_limb = w_a_ext[0 +: LIMB];
            2'd1:    w_a_limb = w_a_ext[LIMB +: LIMB];
            default: w_a_limb = w_a_ext[2*LIMB +: LIMB];
        endcase
        case (w_j)
            2'd0:    w_b_limb = w_b_ext[0 +: LIMB];
            2'd1:    w_b_limb = w_b_ext[LIMB +: LIMB];
            default: w_b_limb = w_b_ext[2*LIMB +: LIMB];
        endcase
    end

    assign w_mul_term   = PW'(w_b_limb) << r_bit;
    assign w_last_bit   = (r_bit == BW'(LIMB - 1));
    assign w_final      = (r_k == 4'd8);
    assign w_sum        = {1'b0, w_i} + {1'b0, w_j};
    assign w_acc_next   = r_acc ^ (AW'(r_p) << (LIMB * int'(w_sum)));
    // Bits above 2N-1 of the accumulator stay zero for any real product.
    assign w_unused_acc = ^w_acc_next;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_MUL;
            S_MUL:   if (w_last_bit) w_next = S_ACC;
            S_ACC:   w_next = w_final ? S_IDLE : S_MUL;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready       = (r_state == S_IDLE);
        busy        = (r_state != S_IDLE);
        done        = r_done;
        c           = r_c;
        o_dbg_state = r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_p    <= '0;
            r_acc  <= '0;
            r_k    <= '0;
            r_bit  <= '0;
            r_done <= 1'b0;
            r_c    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_acc <= '0;
                        r_p   <= '0;
                        r_k   <= '0;
                        r_bit <= '0;
                    end
                end
                S_MUL: begin
                    if (w_a_limb[r_bit]) r_p <= r_p ^ w_mul_term;
                    r_bit <= r_bit + 1'b1;
                end
                S_ACC: begin
                    r_acc <= w_acc_next;
                    r_p   <= '0;
                    r_bit <= '0;
                    if (w_final) begin
                        r_c    <= w_acc_next[2*N-1:0];
                        r_done <= 1'b1;
                    end else begin
                        r_k <= r_k + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tc3_serial_scheduler.sv
// Bench for tc3_serial_scheduler: directed and random operands on the full-size
// instance plus a small-parameter instance for a bulk random sweep.
module tb_tc3_serial_scheduler;

    localparam int BN   = 571;
    localparam int BL   = 191;
    localparam int BLAT = 9 * (BL + 1);
    localparam int SN   = 16;
    localparam int SL   = 6;
    localparam int SLAT = 9 * (SL + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [BN-1:0]   a = '0;
    logic [BN-1:0]   b = '0;
    logic            ready, busy, done;
    logic [2*BN-1:0] c;
    logic [1:0]      dbg_state;

    logic            s_start = 1'b0;
    logic [SN-1:0]   s_a = '0;
    logic [SN-1:0]   s_b = '0;
    logic            s_ready, s_busy, s_done;
    logic [2*SN-1:0] s_c;
    logic [1:0]      s_dbg_state;

    int              vectors = 0;
    int              miscompares = 0;
    logic [2*BN-1:0] exp_q[$];
    logic [2*BN-1:0] last_c = '0;

    tc3_serial_scheduler #(.N(BN), .LIMB(BL)) u_big (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done), .c(c), .o_dbg_state(dbg_state)
    );

    tc3_serial_scheduler #(.N(SN), .LIMB(SL)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b),
        .ready(s_ready), .busy(s_busy), .done(s_done), .c(s_c), .o_dbg_state(s_dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference: schoolbook carry-less product
    function automatic logic [2*BN-1:0] clmul(input logic [BN-1:0] x, input logic [BN-1:0] y);
        logic [2*BN-1:0] r;
        r = '0;
        for (int i = 0; i < BN; i++)
            if (x[i]) r = r ^ ((2*BN)'(y) << i);
        return r;
    endfunction

    function automatic logic [BN-1:0] rand_op();
        logic [BN-1:0] r;
        for (int i = 0; i < BN; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic chk(input string tag, input logic [2*BN-1:0] obs, input logic [2*BN-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic big_accept(input logic [BN-1:0] ta, input logic [BN-1:0] tb);
        a = ta;
        b = tb;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("accept_busy", (2*BN)'(busy), 1);
        exp_q.push_back(clmul(ta, tb));
    endtask

    task automatic big_wait(input string tag, input bit disturb);
        int n;
        logic [2*BN-1:0] e;
        n = 0;
        while (done !== 1'b1 && n < BLAT + 10) begin
            if (disturb) begin
                a = rand_op();
                b = rand_op();
                start = (n == 4 || n == 999);
            end
            step();
            n++;
            if (n == 500) chk({tag, "_c_hold"}, c, last_c);
        end
        start = 1'b0;
        chk({tag, "_latency"}, (2*BN)'(n), (2*BN)'(BLAT));
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk({tag, "_c"}, c, e);
        last_c = e;
    endtask

    initial begin
        logic [BN-1:0]   t;
        logic [2*BN-1:0] e;
        int              seen;
        int              n;

        rst = 1'b1;
        step();
        step();
        chk("rst_c", c, '0);
        chk("rst_done", (2*BN)'(done), 0);
        chk("rst_ready", (2*BN)'(ready), 1);
        chk("rst_busy", (2*BN)'(busy), 0);
        chk("rst_small_c", (2*BN)'(s_c), '0);
        rst = 1'b0;
        step();

        big_accept(1, 1);
        big_wait("one", 0);
        chk("one_const", c, 1);
        chk("one_pulse_hi", (2*BN)'(done), 1);
        step();
        chk("one_pulse_lo", (2*BN)'(done), 0);
        chk("one_ready", (2*BN)'(ready), 1);

        big_accept(3, 3);
        big_wait("x3", 0);
        chk("x3_const", c, 5);

        t = '0;
        t[570] = 1'b1;
        big_accept(t, t);
        big_wait("sq570", 0);
        e = '0;
        e[1140] = 1'b1;
        chk("sq570_const", c, e);

        t = '0;
        t[190] = 1'b1;
        e = '0;
        e[191] = 1'b1;
        big_accept(t, e[BN-1:0]);
        big_wait("cross", 0);
        e = '0;
        e[381] = 1'b1;
        chk("cross_const", c, e);

        t = '1;
        big_accept(t, t);
        big_wait("ones", 0);

        big_accept(rand_op(), rand_op());
        big_wait("handshake", 1);

        // reset lands on edge 800 of an operation
        big_accept(rand_op(), rand_op());
        seen = 0;
        repeat (799) begin
            step();
            if (done) seen++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        last_c = '0;
        chk("midrst_c", c, '0);
        chk("midrst_ready", (2*BN)'(ready), 1);
        chk("midrst_busy", (2*BN)'(busy), 0);
        chk("midrst_done", (2*BN)'(done), 0);
        repeat (2000) begin
            step();
            if (done) seen++;
        end
        chk("midrst_no_done", (2*BN)'(seen), 0);

        rst = 1'b1;
        start = 1'b1;
        a = 5;
        b = 5;
        step();
        rst = 1'b0;
        start = 1'b0;
        chk("rst_wins_ready", (2*BN)'(ready), 1);
        chk("rst_wins_busy", (2*BN)'(busy), 0);
        step();
        chk("rst_wins_idle", (2*BN)'(busy), 0);

        big_accept(6, 7);
        big_wait("x67", 0);
        chk("x67_const", c, 18);

        big_accept(rand_op(), rand_op());
        big_wait("b2b_first", 0);
        chk("b2b_ready_in_done", (2*BN)'(ready), 1);
        big_accept(rand_op(), rand_op());
        big_wait("b2b_second", 0);

        repeat (4) begin
            big_accept(rand_op(), rand_op());
            big_wait("rand_big", 0);
        end

        // bulk random sweep on the small instance
        for (int k = 0; k < 200; k++) begin
            s_a = 16'($urandom_range(0, 65535));
            s_b = 16'($urandom_range(0, 65535));
            if (k == 0) s_a = '0;
            if (k == 1) s_b = '0;
            if (k == 2) begin s_a = '1; s_b = '1; end
            if (k == 3) begin s_a = 16'h8000; s_b = 16'h8000; end
            e = clmul(BN'(s_a), BN'(s_b));
            s_start = 1'b1;
            step();
            s_start = 1'b0;
            n = 0;
            while (s_done !== 1'b1 && n < SLAT + 10) begin
                step();
                n++;
            end
            chk("small_latency", (2*BN)'(n), (2*BN)'(SLAT));
            chk("small_c", (2*BN)'(s_c), e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tc3_serial_scheduler.md
Name: tc3_serial_scheduler

Overview:
- Area-reduced 3-way split GF(2)[x] (carry-less) multiplier controller. One shared bit-serial shift-and-xor partial-product engine is time-multiplexed over all 9 limb products a_i*b_j, instead of 9 parallel engines.
- Sequences limb pairs, accumulates each partial into a 2N-bit result at offset (i+j)*LIMB, and reports completion through a start/ready/done handshake.
- Sits in place of a parallel Toom-Cook-split multiplier wherever latency is non-critical, e.g. the field-multiply unit of a GF(2^571) ECC core.

Parameters:
- N, 571, operand width in bits.
- LIMB, 191, limb width. Must satisfy 3*LIMB >= N. Operands are zero-extended to 3*LIMB bits.

Ports:
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a multiply; accepted only when ready=1
- a  input  N  operand A, sampled on the accept edge
- b  input  N  operand B, sampled on the accept edge
- ready  output  1  high in IDLE, i.e. a start will be accepted
- busy  output  1  high from the accept edge until done is asserted
- done  output  1  one-cycle pulse; c is valid from this cycle on
- c  output  2N  product a*b over GF(2), bit k = coefficient of x^k

Behaviour:
- Reset (rst=1 at an edge, in any state, including mid-operation):
  - state=IDLE, ready=1, busy=0, done=0, c=0.
  - Accumulator, partial register, pair index and bit counter cleared.
  - Any operation in flight is discarded and no done is produced for it.
- Limbs: a_i = a_ext[i*LIMB +: LIMB] and b_j likewise, for i,j in 0..2.
- Fixed pair order k=0..8: (0,0),(0,1),(1,0),(0,2),(1,1),(2,0),(1,2),(2,1),(2,2).
- Registers:
  - a_r, b_r: N-bit operand capture.
  - p: 2*LIMB-bit partial product.
  - acc: 6*LIMB-bit accumulator.
  - k: 4-bit pair index.
  - bit: counter, ceil(log2(LIMB)) bits.
- States:
  - IDLE: ready=1. On start=1, capture a and b, clear acc, p, k and bit, and go to MUL. When start=0, stay in IDLE.
  - MUL:
    - Each cycle: if a_i[bit]=1 then p <= p ^ (b_j << bit); bit <= bit+1.
    - When bit==LIMB-1, the update still applies that cycle, then go to ACC. MUL therefore lasts exactly LIMB cycles per pair.
  - ACC:
    - acc <= acc ^ (p << ((i+j)*LIMB)); p <= 0; bit <= 0.
    - If k<8: k <= k+1 and go to MUL.
    - If k==8: c <= low 2N bits of the updated acc, done <= 1, and go to IDLE.
- Latency: 9*(LIMB+1) edges from the accept edge to the edge that raises done. This is 1728 for LIMB=191.
  - done is high for exactly one cycle.
  - ready returns to 1 in that same cycle, so a new start can be accepted in the done cycle, giving back-to-back operation.
- Handshake rules:
  - busy = ~ready.
  - start while busy is ignored: no queuing and no error.
  - a and b changes after the accept edge have no effect.
  - c holds its value until the next completion or reset. It is not cleared on accept.
- Width rules:
  - All arithmetic is XOR. There are no carries.
  - The true product has degree at most 2N-2, so acc bits above 2N-1 are always zero.
  - Shifts are zero-filling. b_j << bit never exceeds 2*LIMB-1 bits.
- Boundary cases:
  - a=0 or b=0 still takes the full latency and gives c=0.
  - Padding bits of the top limb (3*LIMB-N bits) are zero and contribute nothing.
  - The bit counter never wraps: ACC resets it.
  - rst and start high in the same cycle: rst wins.

Test Plan:
- Reset: assert rst for 2 cycles -> c=0, done=0, ready=1, busy=0. Then start with a=1, b=1 -> done exactly 1728 edges after the accept edge, c=1, single-cycle done pulse.
- Carry-less check: a=3 (x+1), b=3 -> c=5 (x^2+1, no carry). Then a=2^570, b=2^570 -> c=2^1140; this exercises pair (2,2) at offset 4*LIMB.
- Cross-limb products:
  - a=2^190, b=2^191 -> c=2^381; this exercises pair (0,1)/(1,0) boundaries.
  - a=all-ones(571), b=all-ones(571) -> c equals a software carry-less multiply.
  - Add 200 random operand pairs checked against the same software model.
- Handshake: pulse start again at cycles 5 and 1000 after accept with different a and b -> both ignored and the result is for the first operands. Change a and b right after accept -> no effect on c.
- Reset mid-operation: rst at edge 800 of an operation -> no done for it and c=0. Then a new start with a=6, b=7 -> c=18 after 1728 edges.
- Back-to-back: assert start in the done cycle with new operands -> accepted immediately. Previous c stays stable until the second done, 1728 edges later.
